axi_line_refill_master: RTL

- Single-outstanding AXI read-burst master that refills one cache line per miss.
- Sits directly upstream of the two-master AXI read arbiter/mux: one instance per cache (I and D), each driving one master port (req/grnt plus AR/R channels).
- Accepts a miss request, wins bus arbitration, issues one INCR burst, assembles the beats into a line buffer and hands the complete line to the cache.

---
 rtl/axi_line_refill_master_pkg.sv | 24 ++
 rtl/axi_line_refill_master_if.sv | 37 +++
 rtl/axi_line_refill_master_line_buf.sv | 33 +++
 rtl/axi_line_refill_master.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/axi_line_refill_master_pkg.sv
// Shared definitions for the cache-line refill master.
// Contents: AXI encodings used on the AR channel and R response, the refill FSM state
// type, and the helper that derives the line offset width from the words-per-line count.
package axi_line_refill_master_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        DONE
    } refill_state_e;

    // Byte-offset width of one line of 32-bit words.
    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/axi_line_refill_master_if.sv
// Bus-side signal bundle of one refill master: arbiter request/grant plus the AXI AR and R
// channels. The master modport belongs to the refill master; the slave modport belongs to
// the arbiter/mux (or a bench standing in for it).
interface axi_line_refill_master_if;

    logic        req;
    logic        grnt;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output req, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output rready,
        input  grnt, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  req, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  rready,
        output grnt, arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_line_refill_master_line_buf.sv
// Line buffer for the refill master: one 32-bit word written per beat at a word index,
// whole line read out flat (word i at bits [32i+31:32i]).
// Ports: i_clk, i_rst_n (async active-low), i_clr (zero all words), i_we/i_idx/i_wdata
// (word write), o_line (flat line read-out).
module axi_line_refill_master_line_buf #(
    parameter int unsigned  LINE_WORDS = 8,
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [31:0]             i_wdata,
    output logic [32*LINE_WORDS-1:0] o_line
);

    logic [LINE_WORDS-1:0][31:0] r_words;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_words <= '0;
        end else if (i_clr) begin
            // Cleared per miss so words a short burst never delivers read as zero.
            r_words <= '0;
        end else if (i_we) begin
            r_words[i_idx] <= i_wdata;
        end
    end

    assign o_line = r_words;

endmodule

// File: rtl/axi_line_refill_master.sv
// Single-outstanding AXI read-burst master refilling one cache line per miss.
// Accepts a miss, requests the bus, issues one burst of LINE_WORDS beats, assembles the
// line and holds it for the cache until acknowledged.
// Ports: i_clk, i_rst_n (async active-low); cache side i_miss_valid/i_miss_addr/o_miss_ready,
// o_refill_valid/o_refill_addr/o_refill_data/o_refill_err/i_refill_ack; bus side via the
// master modport of axi_line_refill_master_if (req/grnt, AR and R channels).
// Optional build macro CRITICAL_WORD_FIRST_EN: WRAP burst starting at the missed word, plus
// o_crit_valid/o_crit_data carrying the first beat. Undefined: INCR burst from the line base.
module axi_line_refill_master
    import axi_line_refill_master_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [3:0]  ARID_VAL   = 4'h0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_miss_valid,
    input  logic [31:0]              i_miss_addr,
    output logic                     o_miss_ready,
    output logic                     o_refill_valid,
    output logic [31:0]              o_refill_addr,
    output logic [32*LINE_WORDS-1:0] o_refill_data,
    output logic                     o_refill_err,
    input  logic                     i_refill_ack,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic                     o_crit_valid,
    output logic [31:0]              o_crit_data,
`endif
    axi_line_refill_master_if.master bus
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W = $clog2(LINE_WORDS) + 1;

    localparam logic [31:0]      OFF_MASK = (32'h1 << OFF_W) - 32'h1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    refill_state_e    r_state;
    refill_state_e    w_state_next;
    logic [31:0]      r_base;
    logic [31:0]      r_araddr;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;      // beats accepted, saturating at LINE_WORDS
    logic [IDX_W-1:0] w_widx;
    logic             w_accept;
    logic             w_beat;
    logic             w_room;
    logic             w_beat_err;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] r_widx;     // write index, starts at the missed word and wraps
    logic             r_crit_valid;
    logic [31:0]      r_crit_data;
`endif

    assign w_accept = i_miss_valid & o_miss_ready;
    assign w_beat   = (r_state == DATA) & bus.rvalid;
    assign w_room   = (r_cnt < CNT_MAX);
    // Any rlast not on the final expected beat (early, or after surplus beats) is an error.
    assign w_beat_err = (bus.rresp != RESP_OKAY) | (bus.rid != ARID_VAL) |
                        (bus.rlast & (r_cnt != LAST_IDX));

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_widx = r_widx;
`else
    assign w_widx = r_cnt[IDX_W-1:0];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_miss_valid)          w_state_next = ARB;
            ARB:     if (bus.grnt)              w_state_next = ADDR;
            ADDR:    if (bus.arready)           w_state_next = DATA;
            DATA:    if (w_beat && bus.rlast)   w_state_next = DONE;
            DONE:    if (i_refill_ack)          w_state_next = IDLE;
            default:                            w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_araddr <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_widx       <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_base <= i_miss_addr & ~OFF_MASK;
                r_err  <= 1'b0;
                r_cnt  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
                r_araddr <= i_miss_addr & ~32'h3;
                r_widx   <= i_miss_addr[OFF_W-1:2];
`else
                r_araddr <= i_miss_addr & ~OFF_MASK;
`endif
            end
            if (w_beat) begin
                if (w_room) begin
                    r_cnt <= r_cnt + CNT_W'(1);
`ifdef CRITICAL_WORD_FIRST_EN
                    r_widx <= r_widx + IDX_W'(1);
`endif
                end
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
`ifdef CRITICAL_WORD_FIRST_EN
            r_crit_valid <= w_beat & (r_cnt == '0);
            if (w_beat && (r_cnt == '0)) begin
                r_crit_data <= bus.rdata;
            end
`endif
        end
    end

    axi_line_refill_master_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_accept),
        .i_we    (w_beat & w_room),
        .i_idx   (w_widx),
        .i_wdata (bus.rdata),
        .o_line  (o_refill_data)
    );

    // Request held from ARB through DATA so the arbiter keeps the grant for the whole burst.
    assign bus.req     = (r_state == ARB) | (r_state == ADDR) | (r_state == DATA);
    assign bus.arvalid = (r_state == ADDR);
    assign bus.rready  = (r_state == DATA);
    assign bus.arid    = ARID_VAL;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = 4'(LINE_WORDS - 1);
    assign bus.arsize  = SIZE_WORD;
`ifdef CRITICAL_WORD_FIRST_EN
    assign bus.arburst = BURST_WRAP;
    assign o_crit_valid = r_crit_valid;
    assign o_crit_data  = r_crit_data;
`else
    assign bus.arburst = BURST_INCR;
`endif
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;

    assign o_miss_ready   = (r_state == IDLE);
    assign o_refill_valid = (r_state == DONE);
    assign o_refill_addr  = r_base;
    assign o_refill_err   = r_err;

endmodule
